// File: rtl/string_reader.sv
// string_reader: read side of the SME string buffer. Streams stored
// characters one per transfer over valid/ready to the match engine.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, abort        begin a pass (IDLE only) / cancel the current pass
//   start_pos, slen     first index to emit / string length (sampled at start)
//   str_flat            buffer contents, char i at [DW*i +: DW]
//   out_valid/out_ready handshake for out_char, out_idx, out_last
//   busy                pass in progress
//   done                one-cycle pulse on normal completion
//
// Build option: STR_RD_BOUNDARY_EN appends a word-boundary space (8'h20)
// with out_idx=end after the last buffer character of every pass.
module string_reader #(
    parameter int MAX_LEN = 40,
    parameter int DW      = 8,
    parameter int AW      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [AW-1:0]         start_pos,
    input  logic [AW-1:0]         slen,
    input  logic [DW*MAX_LEN-1:0] str_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_char,
    output logic [AW-1:0]         out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW-1:0] MAX_A = AW'(MAX_LEN);
    localparam logic [AW-1:0] ONE_A = AW'(1);
    localparam logic [DW-1:0] SPACE = DW'(8'h20);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] end_q, end_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    logic [AW-1:0] end_in;
    logic [AW-1:0] final_idx;
    logic [AW-1:0] idx_inc;
    logic          xfer;

    // Clamp the requested length to the physical buffer size.
    assign end_in  = (slen > MAX_A) ? MAX_A : slen;
    assign idx_inc = idx_q + ONE_A;
    assign xfer    = valid_q & out_ready;

    // Index carrying out_last for the pass in flight.
`ifdef STR_RD_BOUNDARY_EN
    assign final_idx = end_q;
`else
    assign final_idx = end_q - ONE_A;
`endif

    always_comb begin
        state_d = state_q;
        end_d   = end_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    end_d = end_in;
`ifdef STR_RD_BOUNDARY_EN
                    state_d = S_RUN;
                    valid_d = 1'b1;
                    if (start_pos >= end_in) begin
                        idx_d  = end_in;
                        last_d = 1'b1;
                    end else begin
                        idx_d  = start_pos;
                        last_d = 1'b0;
                    end
`else
                    if (start_pos >= end_in) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        valid_d = 1'b1;
                        idx_d   = start_pos;
                        last_d  = (start_pos == end_in - ONE_A);
                    end
`endif
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        // Load the next slot on the same edge: no bubble.
                        idx_d  = idx_inc;
                        last_d = (idx_inc == final_idx);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
        // Abort wins over a same-cycle transfer; the char is not consumed.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            end_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            end_q   <= end_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Buffer is read live at the current index; it is held stable while busy.
    always_comb begin
        out_char = '0;
        if (valid_q) begin
            if (idx_q < MAX_A) begin
                out_char = str_flat[DW*int'(idx_q) +: DW];
            end
`ifdef STR_RD_BOUNDARY_EN
            if (idx_q == end_q) begin
                out_char = SPACE;
            end
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_string_reader.sv
// tb_string_reader: directed + randomized passes against a queue-based
// model of the expected character stream.
module tb_string_reader;

    localparam int MAX_LEN = 40;
    localparam int DW      = 8;
    localparam int AW      = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [AW-1:0]         start_pos = '0;
    logic [AW-1:0]         slen = '0;
    logic [DW*MAX_LEN-1:0] str_flat = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DW-1:0]         out_char;
    logic [AW-1:0]         out_idx;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    string_reader #(.MAX_LEN(MAX_LEN), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .start_pos (start_pos),
        .slen      (slen),
        .str_flat  (str_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        int         idx;
        logic       last;
    } item_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [MAX_LEN];
    item_t      exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_str(input bit hello);
        string s;
        s = "HELLO";
        for (int i = 0; i < MAX_LEN; i++) begin
            mem[i] = 8'($urandom_range(33, 126));
            if (hello && i < 5) mem[i] = s[i];
            str_flat[DW*i +: DW] = mem[i];
        end
    endtask

    // Expected stream: every stored char from sp up to the clamped
    // length, optionally followed by a boundary space; last one flagged.
    task automatic build_model(input int sl, input int sp);
        int e;
        item_t it;
        exp_q.delete();
        e = (sl > MAX_LEN) ? MAX_LEN : sl;
        for (int i = sp; i < e; i++) begin
            it.ch = mem[i];
            it.idx = i;
            it.last = 1'b0;
            exp_q.push_back(it);
        end
`ifdef STR_RD_BOUNDARY_EN
        it.ch = 8'h20;
        it.idx = e;
        it.last = 1'b0;
        exp_q.push_back(it);
`endif
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // mode: 0 ready always 1, 1 ready pattern 1,0,0, 2 random ready
    task automatic run_pass(input int sl, input int sp, input int mode,
                            input int abort_at, input int rst_at,
                            input bit hold_start);
        int  n;
        int  cyc;
        bit  ended;
        bit  rdy;
        item_t h;
        slen = AW'(sl);
        start_pos = AW'(sp);
        build_model(sl, sp);
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        if (exp_q.size() == 0) begin
            chk("empty_done", 32'(done), 32'd1);
            chk("empty_valid", 32'(out_valid), 32'd0);
            chk("empty_busy", 32'(busy), 32'd0);
            start = 1'b0;
            tick();
            check_idle("empty_after");
            return;
        end
        n = 0;
        cyc = 0;
        ended = 0;
        while (!ended && cyc < 200) begin
            cyc++;
            h = exp_q[0];
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("char", 32'(out_char), 32'(h.ch));
            chk("idx", 32'(out_idx), 32'(h.idx));
            chk("last", 32'(out_last), 32'(h.last));
            if (n == abort_at) begin
                out_ready = 1'b1;
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_idle("abort");
                tick();
                check_idle("abort_after");
                ended = 1;
            end else if (n == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                start = 1'b0;
                check_idle("rst");
                chk("rst_char", 32'(out_char), 32'd0);
                chk("rst_idx", 32'(out_idx), 32'd0);
                chk("rst_last", 32'(out_last), 32'd0);
                ended = 1;
            end else begin
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = (cyc % 3) == 1;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                out_ready = rdy;
                tick();
                if (rdy) begin
                    void'(exp_q.pop_front());
                    n++;
                    if (exp_q.size() == 0) begin
                        chk("fin_done", 32'(done), 32'd1);
                        chk("fin_valid", 32'(out_valid), 32'd0);
                        chk("fin_busy", 32'(busy), 32'd0);
                        tick();
                        check_idle("fin_after");
                        start = 1'b0;
                        ended = 1;
                    end
                end
            end
        end
        if (!ended) begin
            chk("timeout", 32'd1, 32'd0);
        end
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        load_str(1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        chk("reset_char", 32'(out_char), 32'd0);
        chk("reset_idx", 32'(out_idx), 32'd0);
        chk("reset_last", 32'(out_last), 32'd0);

        load_str(1'b1);
        run_pass(5, 0, 0, -1, -1, 1'b0);
        run_pass(5, 0, 1, -1, -1, 1'b0);

        load_str(1'b0);
        run_pass(3, 3, 0, -1, -1, 1'b0);
        run_pass(0, 0, 0, -1, -1, 1'b0);

        run_pass(50, 0, 2, -1, -1, 1'b0);
        run_pass(50, 38, 0, -1, -1, 1'b0);

        load_str(1'b1);
        run_pass(5, 0, 0, 2, -1, 1'b0);
        run_pass(5, 0, 0, -1, -1, 1'b0);
        run_pass(5, 0, 0, -1, 1, 1'b0);
        run_pass(4, 1, 1, -1, -1, 1'b1);

        for (int k = 0; k < 20; k++) begin
            int sl;
            int sp;
            load_str(1'b0);
            sl = $urandom_range(0, 50);
            sp = $urandom_range(0, sl + 2);
            run_pass(sl, sp, 2, -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
